spart_driver: RTL and testbench
===============================

SPART_DRIVER -- requirements
Module: spart_driver

Interface
REQ-001 SHALL have parameter DIV_4800, default 16'd650, divisor for 4800 baud at a 50 MHz clock with 16x oversampling.
REQ-002 SHALL have parameters DIV_9600, DIV_19200 and DIV_38400, with defaults 16'd325, 16'd162 and 16'd80, with the same meaning as DIV_4800.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
REQ-006 SHALL have port rda  input  1  receive data available from the SPART.
REQ-007 SHALL have port tbr  input  1  transmit buffer ready from the SPART.
REQ-008 SHALL have port iocs  output  1  SPART chip select.
REQ-009 SHALL have port iorw  output  1  1=read, 0=write.
REQ-010 SHALL have port ioaddr  output  2  register address: 00=rx/tx buffer, 01=status, 10=divisor low, 11=divisor high.
REQ-011 SHALL have port databus  inout  8  shared SPART data bus.
REQ-012 SHALL have port last_char  output  8  most recent character read.
REQ-013 SHALL have port cfg_done  output  1  high once a divisor matching the current br_cfg is loaded.

Function
REQ-014 SHALL implement FSM states INIT, CFG_LO, CFG_HI, IDLE, READ, WAIT_TBR and WRITE.
REQ-015 SHALL follow the transitions INIT->CFG_LO->CFG_HI->IDLE, each taking one cycle and each unconditional.
REQ-016 In IDLE: if br_cfg differs from the latched cfg, SHALL go to CFG_LO; else if rda=1, SHALL go to READ; else SHALL stay in IDLE; reconfiguration wins over a simultaneous rda.
REQ-017 SHALL go READ->WAIT_TBR in one cycle, capturing databus into last_char at the end of the READ cycle.
REQ-018 SHALL go WAIT_TBR->WRITE when tbr=1, and stay in WAIT_TBR otherwise.
REQ-019 SHALL go WRITE->IDLE in one cycle.
REQ-020 In CFG_LO, outputs SHALL be iocs=1, iorw=0, ioaddr=10, with databus driving divisor[7:0].
REQ-021 In CFG_HI, outputs SHALL be iocs=1, iorw=0, ioaddr=11, with databus driving divisor[15:8].
REQ-022 In READ, outputs SHALL be iocs=1, iorw=1, ioaddr=00, with databus in high-Z.
REQ-023 In WRITE, outputs SHALL be iocs=1, iorw=0, ioaddr=00, with databus driving last_char.
REQ-024 In INIT, IDLE and WAIT_TBR, outputs SHALL be iocs=0, iorw=0, ioaddr=01, with databus in high-Z.
REQ-025 SHALL drive databus only in CFG_LO, CFG_HI and WRITE, and never while iorw=1.
REQ-026 SHALL latch br_cfg and select the divisor in the CFG_LO cycle; both CFG bytes SHALL come from that one latched value, even if br_cfg changes during CFG_HI.
REQ-027 SHALL set cfg_done=1 on entry to IDLE from CFG_HI, and clear it on entry to CFG_LO.
REQ-028 SHALL ignore rda outside IDLE; a character arriving during READ, WAIT_TBR or WRITE is serviced on the next visit to IDLE, since rda stays high.
REQ-029 SHALL complete each echo with exactly one READ pulse and one WRITE pulse, each one cycle wide.

Reset
REQ-030 When rst_n=0 at a posedge, SHALL set state=INIT, last_char=8'h00, cfg_done=0 and latched cfg=2'b00.
REQ-031 SHALL abort any operation in progress on reset, with no partial write completed; the next posedge after release starts the CFG sequence again.
REQ-032 SHALL provide, in the cycle after a reset edge, iocs=0, iorw=0, ioaddr=01 and databus in high-Z.

Structure
REQ-033 SHALL place the SPART address constants (ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH) and the FSM state encoding in a shared package spart_pkg, used by the receive and transmit buffers too.
REQ-034 SHALL be a single module with no sub-modules; divisor selection SHALL be a combinational case on the latched cfg.

Verification
REQ-035 Bench SHALL check: rst_n low 2 cycles then release with br_cfg=01 -> CFG_LO drives 8'h45 at ioaddr 10, next cycle CFG_HI drives 8'h01 at ioaddr 11, then cfg_done=1.
REQ-036 Bench SHALL check: in IDLE, rda=1 with model bus 8'h41 and tbr=1 -> READ pulse, then WAIT_TBR, then WRITE drives 8'h41 at ioaddr 00, and last_char=8'h41.
REQ-037 Bench SHALL check: tbr held 0 for 20 cycles after READ -> stays in WAIT_TBR with iocs=0, and WRITE occurs exactly 1 cycle after tbr rises.
REQ-038 Bench SHALL check: br_cfg changes 01->11 in the same cycle rda=1 -> CFG_LO/HI write 8'h50/8'h00 first, then the character is echoed.
REQ-039 Bench SHALL check: rst_n=0 during WAIT_TBR -> no WRITE pulse, last_char=00, and the CFG sequence repeats.
REQ-040 Bench SHALL check: an assertion over all cycles that databus is never driven while iorw=1.

Source files
------------

// File: rtl/spart_pkg.sv
// spart_pkg: SPART register addresses and driver FSM state encoding, shared by the driver and the rx/tx buffers
package spart_pkg;
  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;
  typedef enum logic [2:0] {
    INIT, CFG_LO, CFG_HI, IDLE, READ, WAIT_TBR, WRITE
  } state_t;
endpackage

// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor from br_cfg and echoes each received char (clk, rst_n, br_cfg, rda, tbr -> iocs, iorw, ioaddr, databus, last_char, cfg_done)
module spart_driver
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_4800  = 16'd650,
  parameter logic [15:0] DIV_9600  = 16'd325,
  parameter logic [15:0] DIV_19200 = 16'd162,
  parameter logic [15:0] DIV_38400 = 16'd80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] last_char,
  output logic       cfg_done
);
  state_t     r_state, w_next;
  logic [1:0] r_cfg;
  logic [7:0] r_last;
  logic       r_done;
  logic [15:0] w_div;
  logic [7:0] w_dout;
  logic       w_oe;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cfg   <= 2'b00;
      r_last  <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cfg   <= (w_next == CFG_LO) ? br_cfg : r_cfg;
      r_last  <= (r_state == READ) ? databus : r_last;
      r_done  <= (r_state == CFG_HI) | (r_done & (w_next != CFG_LO));
    end
  end
  always_comb begin
    w_div = DIV_4800;
    case (r_cfg)
      2'b00: w_div = DIV_4800;
      2'b01: w_div = DIV_9600;
      2'b10: w_div = DIV_19200;
      2'b11: w_div = DIV_38400;
      default: w_div = DIV_4800;
    endcase
  end
  always_comb begin
    w_next = r_state;
    iocs   = 1'b0;
    iorw   = 1'b0;
    ioaddr = ADDR_STAT;
    w_oe   = 1'b0;
    w_dout = r_last;
    case (r_state)
      INIT:     w_next = CFG_LO;
      CFG_LO: begin
        w_next = CFG_HI;
        iocs   = 1'b1;
        ioaddr = ADDR_DBL;
        w_oe   = 1'b1;
        w_dout = w_div[7:0];
      end
      CFG_HI: begin
        w_next = IDLE;
        iocs   = 1'b1;
        ioaddr = ADDR_DBH;
        w_oe   = 1'b1;
        w_dout = w_div[15:8];
      end
      IDLE:     w_next = (br_cfg != r_cfg) ? CFG_LO : rda ? READ : IDLE;
      READ: begin
        w_next = WAIT_TBR;
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = ADDR_BUF;
      end
      WAIT_TBR: w_next = tbr ? WRITE : WAIT_TBR;
      WRITE: begin
        w_next = IDLE;
        iocs   = 1'b1;
        ioaddr = ADDR_BUF;
        w_oe   = 1'b1;
      end
      default:  w_next = INIT;
    endcase
  end
  assign databus   = w_oe ? w_dout : 8'hzz;
  assign last_char = r_last;
  assign cfg_done  = r_done;
endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: randomized self-checking bench for spart_driver against a bus-transaction reference model
module tb_spart_driver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic       iocs, iorw, cfg_done;
  logic [1:0] ioaddr;
  logic [7:0] last_char;
  logic [7:0] tb_rx = 8'h00;
  wire  [7:0] databus;
  int errors = 0;
  int checks = 0;
  logic [10:0] log_q[$];
  spart_driver dut (
    .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .last_char(last_char), .cfg_done(cfg_done)
  );
  assign databus = (iocs === 1'b1 && iorw === 1'b1) ? tb_rx : 8'hzz;
  always #5 clk = ~clk;
  always @(negedge clk) if (iocs === 1'b1) log_q.push_back({iorw, ioaddr, databus});
  always @(negedge clk) begin
    if (iorw === 1'b1) begin
      checks++;
      a_read_bus: assert (iocs === 1'b1 && ioaddr === 2'b00 && databus === tb_rx)
        else begin
          errors++;
          $display("FAIL read_bus_only_spart: iocs=%b ioaddr=%b databus=%h, need 1/00/%h", iocs, ioaddr, databus, tb_rx);
        end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  function automatic logic [15:0] div_of(input logic [1:0] c);
    int baud;
    baud = 4800 << c;
    return 16'((50_000_000 + 8 * baud) / (16 * baud) - 1);
  endfunction
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic test_reset;
    logic [15:0] d;
    d = div_of(2'b01);
    rst_n = 1'b0; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0;
    step; step;
    checks++; if ({iocs, iorw, ioaddr} !== 4'b0001) begin errors++; $display("FAIL rst_ctrl: got %b need 0001", {iocs, iorw, ioaddr}); end
    checks++; if (last_char !== 8'h00) begin errors++; $display("FAIL rst_last_char: got %h need 00", last_char); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL rst_cfg_done: got %b need 0", cfg_done); end
    rst_n = 1'b1;
    step;
    checks++; if ({iocs, iorw, ioaddr, databus} !== {4'b1010, d[7:0]}) begin errors++; $display("FAIL cfg_lo: got %b/%h need 1010/%h", {iocs, iorw, ioaddr}, databus, d[7:0]); end
    step;
    checks++; if ({iocs, iorw, ioaddr, databus} !== {4'b1011, d[15:8]}) begin errors++; $display("FAIL cfg_hi: got %b/%h need 1011/%h", {iocs, iorw, ioaddr}, databus, d[15:8]); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL cfg_done_early: got %b need 0", cfg_done); end
    step;
    checks++; if ({cfg_done, iocs, iorw, ioaddr} !== 5'b10001) begin errors++; $display("FAIL cfg_done_idle: got %b need 10001", {cfg_done, iocs, iorw, ioaddr}); end
  endtask
  task automatic test_echo;
    tb_rx = 8'h41; rda = 1'b1; tbr = 1'b1;
    step;
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1100) begin errors++; $display("FAIL echo_read: got %b need 1100", {iocs, iorw, ioaddr}); end
    rda = 1'b0;
    step;
    checks++; if ({iocs, iorw, ioaddr, last_char} !== {4'b0001, 8'h41}) begin errors++; $display("FAIL echo_wait: got %b/%h need 0001/41", {iocs, iorw, ioaddr}, last_char); end
    step;
    checks++; if ({iocs, iorw, ioaddr, databus} !== {4'b1000, 8'h41}) begin errors++; $display("FAIL echo_write: got %b/%h need 1000/41", {iocs, iorw, ioaddr}, databus); end
    step;
    checks++; if ({iocs, iorw, ioaddr} !== 4'b0001) begin errors++; $display("FAIL echo_idle: got %b need 0001", {iocs, iorw, ioaddr}); end
  endtask
  task automatic test_tbr_wait;
    logic [7:0] ch;
    int busy;
    ch = 8'($urandom); tb_rx = ch; tbr = 1'b0; rda = 1'b1; busy = 0;
    step;
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1100) begin errors++; $display("FAIL wait_read: got %b need 1100", {iocs, iorw, ioaddr}); end
    rda = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (iocs !== 1'b0) busy++;
    end
    checks++; if (busy !== 0) begin errors++; $display("FAIL wait_tbr_quiet: got %0d busy cycles need 0", busy); end
    tbr = 1'b1;
    step;
    checks++; if ({iocs, iorw, ioaddr, databus} !== {4'b1000, ch}) begin errors++; $display("FAIL wait_write: got %b/%h need 1000/%h", {iocs, iorw, ioaddr}, databus, ch); end
    step;
  endtask
  task automatic test_reconfig;
    logic [15:0] d;
    logic [7:0] ch;
    d = div_of(2'b11); ch = 8'($urandom); tb_rx = ch;
    br_cfg = 2'b11; rda = 1'b1; tbr = 1'b1;
    step;
    checks++; if ({iocs, iorw, ioaddr, databus, cfg_done} !== {4'b1010, d[7:0], 1'b0}) begin errors++; $display("FAIL reconf_lo: got %b/%h/%b need 1010/%h/0", {iocs, iorw, ioaddr}, databus, cfg_done, d[7:0]); end
    step;
    checks++; if ({iocs, iorw, ioaddr, databus} !== {4'b1011, d[15:8]}) begin errors++; $display("FAIL reconf_hi: got %b/%h need 1011/%h", {iocs, iorw, ioaddr}, databus, d[15:8]); end
    step;
    step;
    checks++; if ({iocs, iorw, ioaddr, cfg_done} !== 5'b11001) begin errors++; $display("FAIL reconf_read: got %b need 11001", {iocs, iorw, ioaddr, cfg_done}); end
    rda = 1'b0;
    step; step;
    checks++; if ({iocs, iorw, ioaddr, databus} !== {4'b1000, ch}) begin errors++; $display("FAIL reconf_write: got %b/%h need 1000/%h", {iocs, iorw, ioaddr}, databus, ch); end
    step;
  endtask
  task automatic test_reset_mid;
    logic [15:0] d;
    logic [10:0] exp_q[$];
    logic bad;
    d = div_of(br_cfg);
    exp_q = '{{1'b0, 2'b10, d[7:0]}, {1'b0, 2'b11, d[15:8]}};
    tb_rx = 8'($urandom); tbr = 1'b0; rda = 1'b1;
    step;
    rda = 1'b0;
    step; step;
    log_q.delete();
    rst_n = 1'b0; tbr = 1'b1;
    step;
    checks++; if ({iocs, iorw, ioaddr, last_char, cfg_done} !== {4'b0001, 8'h00, 1'b0}) begin errors++; $display("FAIL midrst_state: got %b/%h/%b need 0001/00/0", {iocs, iorw, ioaddr}, last_char, cfg_done); end
    rst_n = 1'b1; tbr = 1'b0;
    step; step; step;
    bad = (log_q.size() != exp_q.size());
    for (int i = 0; i < exp_q.size() && !bad; i++) bad = (log_q[i] !== exp_q[i]);
    checks++; if (bad) begin errors++; $display("FAIL midrst_bus: got %0d txns %p need %p", log_q.size(), log_q, exp_q); end
  endtask
  task automatic test_random;
    logic [1:0] cur, nxt;
    logic [7:0] ch, mlast;
    logic [15:0] d;
    logic [10:0] exp_q[$];
    logic echo, bad;
    int dly, k;
    cur = br_cfg; mlast = 8'h00;
    for (int it = 0; it < 30; it++) begin
      nxt = ($urandom_range(0, 2) == 0) ? 2'($urandom) : cur;
      echo = (nxt == cur) ? 1'b1 : 1'($urandom);
      ch = 8'($urandom); dly = $urandom_range(0, 4); d = div_of(nxt);
      exp_q.delete();
      if (nxt != cur) begin
        exp_q.push_back({1'b0, 2'b10, d[7:0]});
        exp_q.push_back({1'b0, 2'b11, d[15:8]});
      end
      if (echo) begin
        exp_q.push_back({1'b1, 2'b00, ch});
        exp_q.push_back({1'b0, 2'b00, ch});
        mlast = ch;
      end
      log_q.delete();
      br_cfg = nxt; rda = echo; tbr = 1'b0; tb_rx = ch;
      if (echo) begin
        k = 0;
        while (k < 12 && !(iocs === 1'b1 && iorw === 1'b1)) begin step; k++; end
        if (k == 12) begin checks++; errors++; $display("FAIL rnd_read_timeout: iter %0d no READ within 12 cycles", it); end
        rda = 1'b0;
        repeat (dly) step;
        tbr = 1'b1;
        step; step; step;
        tbr = 1'b0;
      end else begin
        repeat (4) step;
      end
      bad = (log_q.size() != exp_q.size());
      for (int i = 0; i < exp_q.size() && !bad; i++) bad = (log_q[i] !== exp_q[i]);
      checks++; if (bad) begin errors++; $display("FAIL rnd_bus: iter %0d got %p need %p", it, log_q, exp_q); end
      checks++; if ({last_char, cfg_done} !== {mlast, 1'b1}) begin errors++; $display("FAIL rnd_state: iter %0d got %h/%b need %h/1", it, last_char, cfg_done, mlast); end
      cur = nxt;
    end
  endtask
  initial begin
    test_reset;
    test_echo;
    test_tbr_wait;
    test_reconfig;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
